// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the asynchronous FIFO: issues credit-limited reads, absorbs the
// one-cycle read latency in a 3-entry buffer, and presents words on a valid/ready stream.
module fifo_rd_ctrl #(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk_rd,
    input  logic          rst_n,
    input  logic          en,
    input  logic          empty,
    input  logic [DW-1:0] fifo_dout,
    output logic          re,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [CW-1:0] word_cnt,
    output logic          busy
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2,
        OCC_FULL  = 2'd3
    } occ_e;

    occ_e          occ;
    logic          pend;
    logic [1:0]    head;
    logic [1:0]    tail;
    logic [DW-1:0] mem [3];

    logic          capture;
    logic          pop;
    logic [2:0]    in_use;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit counts both buffered words and the word still in flight, so a read is only
    // issued when its data is guaranteed a slot; m_ready stays out of this path.
    assign in_use  = {1'b0, occ} + {2'b00, pend};
    assign re      = rst_n & en & ~empty & (in_use < 3'd3);

    assign capture = pend;
    assign pop     = m_valid & m_ready;
    assign m_valid = (occ != OCC_EMPTY);
    assign m_data  = mem[head];
    assign busy    = m_valid | pend;

    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 1'b0;
            occ      <= OCC_EMPTY;
            head     <= 2'd0;
            tail     <= 2'd0;
            word_cnt <= '0;
            // NOTE: the buffer is reset too because m_data reads it directly and must be 0 in reset.
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
        end else begin
            pend <= re;
            if (capture) begin
                mem[tail] <= fifo_dout;
                tail      <= ptr_next(tail);
            end
            if (pop) begin
                head     <= ptr_next(head);
                word_cnt <= word_cnt + 1'b1;
            end
            case ({capture, pop})
                2'b10:   occ <= occ_e'(2'(occ + 2'd1));
                2'b01:   occ <= occ_e'(2'(occ - 2'd1));
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: emulates the FIFO, models delivery with queues,
// and compares every cycle; a CW=4 instance shares the stimulus to exercise counter wrap.
module tb_fifo_rd_ctrl;

    localparam int DW = 16;

    logic          clk_rd = 1'b0;
    logic          rst_n  = 1'b0;
    logic          en     = 1'b0;
    logic          empty  = 1'b1;
    logic          m_ready = 1'b0;
    logic [DW-1:0] fifo_dout = '0;

    logic          re, m_valid, busy;
    logic [DW-1:0] m_data;
    logic [15:0]   word_cnt;
    logic          re4, m_valid4, busy4;
    logic [DW-1:0] m_data4;
    logic [3:0]    word_cnt4;

    fifo_rd_ctrl #(.DW(DW), .CW(16)) dut (
        .clk_rd(clk_rd), .rst_n(rst_n), .en(en), .empty(empty), .fifo_dout(fifo_dout),
        .re(re), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .word_cnt(word_cnt), .busy(busy)
    );

    fifo_rd_ctrl #(.DW(DW), .CW(4)) dut4 (
        .clk_rd(clk_rd), .rst_n(rst_n), .en(en), .empty(empty), .fifo_dout(fifo_dout),
        .re(re4), .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
        .word_cnt(word_cnt4), .busy(busy4)
    );

    always #5 clk_rd = ~clk_rd;

    int total = 0;
    int bad   = 0;

    // FIFO contents, output-buffer model, in-flight word and delivered-word count
    logic [DW-1:0] fq[$];
    logic [DW-1:0] mq[$];
    bit            inflight;
    logic [DW-1:0] inflight_word;
    int unsigned   cnt;
    bit            empty_force;

    bit            obs_re;
    int            cyc;
    int            re_pulses, re_run, re_max_run, first_re_cyc, first_v_cyc;
    logic [DW-1:0] got[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic sync_empty();
        empty = empty_force || (fq.size() == 0);
    endtask

    task automatic clear_obs();
        re_pulses    = 0;
        re_run       = 0;
        re_max_run   = 0;
        first_re_cyc = -1;
        first_v_cyc  = -1;
        got.delete();
        fq.delete();
        empty_force  = 1'b0;
        sync_empty();
    endtask

    // One clock cycle: compare at the falling edge, advance the model, then let the FIFO react.
    task automatic step();
        bit re_exp;
        bit pop;
        @(negedge clk_rd);
        re_exp = en && !empty && ((mq.size() + (inflight ? 1 : 0)) < 3);
        check("re", 32'(re), 32'(re_exp));
        check("m_valid", 32'(m_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check("m_data", 32'(m_data), 32'(mq[0]));
        check("busy", 32'(busy), 32'(mq.size() != 0 || inflight));
        check("word_cnt", 32'(word_cnt), 32'(16'(cnt)));
        check("word_cnt4", 32'(word_cnt4), 32'(4'(cnt)));
        check("re4", 32'(re4), 32'(re_exp));
        check("m_valid4", 32'(m_valid4), 32'(mq.size() != 0));
        check("busy4", 32'(busy4), 32'(mq.size() != 0 || inflight));
        if (mq.size() != 0) check("m_data4", 32'(m_data4), 32'(mq[0]));

        obs_re = re;
        if (re) begin
            re_pulses++;
            re_run++;
            if (re_run > re_max_run) re_max_run = re_run;
            if (first_re_cyc < 0) first_re_cyc = cyc;
        end else begin
            re_run = 0;
        end
        if (m_valid && first_v_cyc < 0) first_v_cyc = cyc;

        pop = (mq.size() != 0) && m_ready;
        if (pop) begin
            got.push_back(m_data);
            mq.delete(0);
            cnt++;
        end
        if (inflight) mq.push_back(inflight_word);
        inflight = re_exp;
        if (re_exp) inflight_word = fq[0];

        @(posedge clk_rd);
        #1;
        if (obs_re && fq.size() != 0) fifo_dout = fq.pop_front();
        sync_empty();
        cyc++;
    endtask

    // Asserts reset mid-cycle and checks outputs fall immediately, then releases away from the edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        mq.delete();
        inflight = 1'b0;
        cnt      = 0;
        #1;
        check("rst_re", 32'(re), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_word_cnt4", 32'(word_cnt4), 32'd0);
        repeat (2) @(posedge clk_rd);
        #3 rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((mq.size() != 0 || inflight || (en && !empty_force && fq.size() != 0)) && n < 300) begin
            step();
            n++;
        end
        step();
        if (n >= 300) check({name, "_drain_timeout"}, 32'd0, 32'd1);
    endtask

    logic [DW-1:0] sent[$];
    int            n_ok;
    int            guard;

    initial begin
        empty_force = 1'b0;
        inflight    = 1'b0;
        cnt         = 0;
        cyc         = 0;
        @(posedge clk_rd);
        #1;
        do_reset();

        // Streaming: 16 words, consumer always ready
        clear_obs();
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) fq.push_back(DW'(i));
        sync_empty();
        drain("stream");
        check("stream_re_pulses", 32'(re_pulses), 32'd16);
        check("stream_re_run", 32'(re_max_run), 32'd16);
        check("stream_latency", 32'(first_v_cyc - first_re_cyc), 32'd2);
        check("stream_count", 32'(got.size()), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++) check("stream_order", 32'(got[i]), 32'(i));
        check("stream_word_cnt", 32'(word_cnt), 32'd16);
        check("stream_busy_end", 32'(busy), 32'd0);

        // Backpressure: consumer stalled, then released
        do_reset();
        clear_obs();
        en = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) fq.push_back(DW'(i));
        sync_empty();
        repeat (10) step();
        check("bp_re_pulses", 32'(re_pulses), 32'd3);
        check("bp_m_valid", 32'(m_valid), 32'd1);
        check("bp_m_data", 32'(m_data), 32'd0);
        m_ready = 1'b1;
        drain("bp");
        check("bp_count", 32'(got.size()), 32'd10);
        for (int i = 0; i < 10 && i < got.size(); i++) check("bp_order", 32'(got[i]), 32'(i));
        check("bp_word_cnt", 32'(word_cnt), 32'd10);

        // Empty gating: flag held high though data is queued
        do_reset();
        clear_obs();
        empty_force = 1'b1;
        for (int i = 0; i < 5; i++) fq.push_back(DW'(100 + i));
        sync_empty();
        en = 1'b1;
        m_ready = 1'b1;
        repeat (20) step();
        check("empty_re_pulses", 32'(re_pulses), 32'd0);
        check("empty_m_valid", 32'(m_valid), 32'd0);
        check("empty_busy", 32'(busy), 32'd0);
        empty_force = 1'b0;
        sync_empty();
        drain("empty");
        check("empty_count", 32'(got.size()), 32'd5);

        // Enable drop the cycle after the read for word 4
        do_reset();
        clear_obs();
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) fq.push_back(DW'(i));
        sync_empty();
        guard = 0;
        while (!(obs_re && re_pulses == 5) && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) check("endrop_timeout", 32'd0, 32'd1);
        en = 1'b0;
        drain("endrop");
        check("endrop_re_pulses", 32'(re_pulses), 32'd5);
        check("endrop_word_cnt", 32'(word_cnt), 32'd5);
        if (got.size() == 5) check("endrop_last", 32'(got[4]), 32'd4);
        else check("endrop_count", 32'(got.size()), 32'd5);
        check("endrop_busy", 32'(busy), 32'd0);

        // Counter wrap on the CW=4 instance
        do_reset();
        clear_obs();
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 18; i++) fq.push_back(DW'(200 + i));
        sync_empty();
        drain("wrap");
        check("wrap_word_cnt4", 32'(word_cnt4), 32'd2);
        check("wrap_word_cnt", 32'(word_cnt), 32'd18);

        // Reset mid-stream with two words buffered and one in flight
        do_reset();
        clear_obs();
        en = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) fq.push_back(DW'(i));
        sync_empty();
        guard = 0;
        while (!(mq.size() == 2 && inflight) && guard < 20) begin
            step();
            guard++;
        end
        if (guard >= 20) check("midrst_setup_timeout", 32'd0, 32'd1);
        do_reset();
        got.delete();
        m_ready = 1'b1;
        guard = 0;
        while (!m_valid && guard < 20) begin
            step();
            guard++;
        end
        check("midrst_first_word", 32'(m_data), 32'd3);
        drain("midrst");
        check("midrst_count", 32'(got.size()), 32'd7);

        // Randomized traffic: enable, backpressure, empty flag and FIFO fill all vary
        do_reset();
        clear_obs();
        sent.delete();
        for (int c = 0; c < 2000; c++) begin
            en = ($urandom_range(0, 9) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
                    fq.push_back(DW'($urandom));
                    sent.push_back(fq[fq.size() - 1]);
                end
            end
            empty_force = ($urandom_range(0, 19) == 0);
            sync_empty();
            step();
        end
        empty_force = 1'b0;
        en = 1'b1;
        m_ready = 1'b1;
        sync_empty();
        drain("rand");
        check("rand_word_cnt", 32'(word_cnt), 32'(16'(sent.size())));
        n_ok = 0;
        for (int i = 0; i < sent.size() && i < got.size(); i++) if (got[i] === sent[i]) n_ok++;
        check("rand_order", 32'(n_ok), 32'(sent.size()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
